fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle datapath's decode/execute logic. Holds the fetch PC, issues word reads to instruction memory over a req/ack handshake, buffers returned words with their PCs in a small FIFO, and presents them to the core over valid/ready. Branch/jump targets from the branch unit arrive as a redirect that flushes the queue and restarts fetch, discarding any in-flight read.

## Interface
- DEPTH, 4: queue entries (power of two, 2..16)
- RESET_PC, 32'h0000_0000: fetch address after reset (word aligned)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  word address of current request
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  32  instruction word
- inst_valid  out  1  queue head valid
- inst_ready  in  1  consumer accepts head
- inst  out  32  head instruction word
- inst_pc  out  32  PC of head instruction

## Operation
- Registers: fetch_pc, FSM state, queue (DEPTH × {pc, word}), rd/wr pointers, count (0..DEPTH).
- FSM states: IDLE (no request), REQ (request outstanding, data kept), DROP (request outstanding, data discarded).
- mem_req = (state != IDLE), registered; mem_addr = fetch_pc, registered, stable for whole request.
- IDLE -> REQ when count_next < DEPTH and no redirect.
- REQ, mem_ack=1: push {fetch_pc, mem_rdata}; fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); go REQ if count_next < DEPTH else IDLE.
- REQ, redirect=1 with mem_ack=0: go DROP; fetch_pc <= redirect_pc.
- REQ or DROP, redirect=1 with mem_ack=1: no push; fetch_pc <= redirect_pc; go REQ (issue at new address next cycle).
- DROP, mem_ack=1: no push; go REQ if no further redirect (queue is empty after flush).
- DROP, redirect again: fetch_pc updated, remain DROP.
- IDLE, redirect: fetch_pc <= redirect_pc, then go REQ.
- Pop when inst_valid && inst_ready; push and pop in the same cycle both take effect, count unchanged.
- Redirect: count <= 0, pointers reset, inst_valid drops next cycle; overrides any push or pop that cycle (a pop with redirect is still treated as consumed by the core).
- count_next = count + push − pop, evaluated before redirect override.
- Requests are never retracted: once mem_req is high it stays high with the same mem_addr until mem_ack.
- inst_valid = (count != 0); inst/inst_pc driven from the head entry.

## Timing
- Reset (rst=0): state IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0. Applies immediately, mid-transaction included; the outstanding read is abandoned and memory must tolerate it.
- First edge after rst release: IDLE->REQ; mem_req=1, mem_addr=RESET_PC from that edge on.
- mem_ack sampled on the rising edge while mem_req=1; ack in the first cycle of a request is legal (single-cycle memory).
- Ack-to-inst_valid latency: 1 cycle (word visible the cycle after the ack edge).
- Throughput: with mem_ack always high and inst_ready high, one instruction per cycle, back-to-back requests with no bubbles.
- Full queue (count=DEPTH): mem_req low until a pop makes count_next < DEPTH; request issues the cycle after that pop edge.
- Redirect-to-new-request latency: 1 cycle if no read outstanding or ack coincides; otherwise waits for the dropped ack, then 1 cycle.

## Test plan
- Reset release, mem_ack tied 1, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8,... one per cycle, inst matches memory image, first inst_valid 2 cycles after release.
- inst_ready=0, DEPTH=4 -> exactly 4 pushes, mem_req falls, mem_addr=0x10 held; raise inst_ready for 1 cycle -> next request 0x10 issues following cycle, no duplicates, no lost words.
- mem_ack delayed 3 cycles per request -> mem_addr stable throughout each request, inst_pc increments by 4, no spurious inst_valid.
- Redirect to 0x0000_0100 while request for 0x8 outstanding (ack 2 cycles later) -> word for 0x8 never appears, queue empties next cycle, next mem_addr=0x100, next inst_pc=0x100.
- Redirect coinciding with mem_ack and a pop -> no push, count=0, next request at redirect_pc immediately; redirect_pc=0x103 -> mem_addr=0x100.
- rst asserted mid-request with 3 entries queued -> all outputs at reset values immediately; after release fetch restarts at RESET_PC; fetch_pc wrap from 0xFFFF_FFFC to 0x0 checked separately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: redirect from the branch unit, instruction memory
// req/ack read port, and the valid/ready instruction stream to decode.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one outstanding memory read,
// and a small {pc, word} queue feeding decode; redirects flush and restart.
//
// state | meaning
// IDLE  | no read outstanding (queue full or just reset)
// REQ   | read outstanding, returned word is queued
// DROP  | read outstanding, returned word is discarded (redirected)
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   mem_addr_q;
  logic          mem_req_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   word_q [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] count_d;
  logic          room;
  logic [31:0]   redirect_addr;
  logic [31:0]   pc_inc;

  assign pop           = (count_q != '0) && bus.inst_ready;
  assign push          = (state_q == REQ) && bus.mem_ack && !bus.redirect;
  assign count_d       = count_q + CW'(push) - CW'(pop);
  assign room          = count_d < CW'(DEPTH);
  assign redirect_addr = bus.redirect_pc & ~32'h3;
  assign pc_inc        = fetch_pc_q + 32'd4;

  // mem_addr_q is held separately from fetch_pc_q so a redirect arriving
  // mid-read never changes the address of the read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc_q <= redirect_addr;
            mem_addr_q <= redirect_addr;
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
          end else if (room) begin
            mem_addr_q <= fetch_pc_q;
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            if (bus.redirect) begin
              fetch_pc_q <= redirect_addr;
              mem_addr_q <= redirect_addr;
              mem_req_q  <= 1'b1;
            end else begin
              fetch_pc_q <= pc_inc;
              mem_addr_q <= pc_inc;
              state_q    <= room ? REQ : IDLE;
              mem_req_q  <= room;
            end
          end else if (bus.redirect) begin
            fetch_pc_q <= redirect_addr;
            state_q    <= DROP;
          end
        end
        DROP: begin
          if (bus.mem_ack) begin
            if (bus.redirect) begin
              fetch_pc_q <= redirect_addr;
              mem_addr_q <= redirect_addr;
            end else begin
              mem_addr_q <= fetch_pc_q;
            end
            state_q   <= REQ;
            mem_req_q <= 1'b1;
          end else if (bus.redirect) begin
            fetch_pc_q <= redirect_addr;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else if (bus.redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]   <= fetch_pc_q;
        word_q[wr_ptr_q] <= bus.mem_rdata;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = word_q[rd_ptr_q];
  assign bus.inst_pc    = pc_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural memory, scoreboard of
// expected {pc, word} entries, and an independent in-order PC model.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  ent_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          ready_mode = 1'b1;
  bit          dropping = 1'b0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_pc = RESET_PC;
  int          pops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]} + 32'h1357_9BDF;
  endfunction

  function automatic void clear_model();
    sb.delete();
    wait_cnt     = 0;
    dropping     = 1'b0;
    prev_pending = 1'b0;
    exp_pc       = RESET_PC;
  endfunction

  // One cycle: sample at negedge, play memory and consumer, update the model.
  task automatic step(input bit redir, input logic [31:0] rpc);
    ent_t e;
    @(negedge clk);
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.inst_ready  = ready_mode;
    if (prev_pending) begin
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", bus.mem_req, bus.mem_addr, prev_addr);
      end
    end
    if (bus.mem_req === 1'b1 && wait_cnt >= ack_delay) begin
      bus.mem_ack = 1'b1;
      wait_cnt    = 0;
    end else begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) wait_cnt++;
    end
    bus.mem_rdata = bus.mem_ack ? mem_word(bus.mem_addr) : 32'hDEAD_BEEF;
    n_cmp++;
    if (bus.inst_valid !== (sb.size() != 0)) begin
      n_fail++;
      $display("FAIL inst_valid: got %b, required %b", bus.inst_valid, sb.size() != 0);
    end
    if (bus.inst_valid === 1'b1 && bus.inst_ready && sb.size() != 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.inst_pc !== e.pc || bus.inst !== e.word) begin
        n_fail++;
        $display("FAIL head_entry: got pc=%h inst=%h, required pc=%h inst=%h", bus.inst_pc, bus.inst, e.pc, e.word);
      end
      n_cmp++;
      if (bus.inst_pc !== exp_pc) begin
        n_fail++;
        $display("FAIL pc_sequence: got %h, required %h", bus.inst_pc, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (bus.mem_ack && !redir && !dropping) begin
      e.pc   = bus.mem_addr;
      e.word = mem_word(bus.mem_addr);
      sb.push_back(e);
    end
    if (bus.mem_ack) dropping = 1'b0;
    else if (redir && bus.mem_req === 1'b1) dropping = 1'b1;
    if (redir) begin
      sb.delete();
      exp_pc = rpc & ~32'h3;
    end
    prev_pending = (bus.mem_req === 1'b1) && !bus.mem_ack;
    prev_addr    = bus.mem_addr;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.mem_ack = 1'b0;
    bus.redirect = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== RESET_PC || bus.inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%b addr=%h valid=%b, required 0/%h/0", bus.mem_req, bus.mem_addr, bus.inst_valid, RESET_PC);
    end
    n_cmp++;
    if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: inst=%h inst_pc=%h, required 0/0", bus.inst, bus.inst_pc);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    int p0;
    ready_mode = 1'b1;
    ack_delay  = 0;
    step(1'b0, '0);
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC || bus.inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, required 1/%h/0", bus.mem_req, bus.mem_addr, bus.inst_valid, RESET_PC);
    end
    step(1'b0, '0);
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_valid: valid=%b pc=%h, required 1/%h", bus.inst_valid, bus.inst_pc, RESET_PC);
    end
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0);
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.mem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL throughput: cycle %0d valid=%b req=%b, required 1/1", i, bus.inst_valid, bus.mem_req);
      end
    end
    n_cmp++;
    if (pops - p0 != 10) begin
      n_fail++;
      $display("FAIL stream_count: got %0d pops, required 10", pops - p0);
    end
  endtask

  task automatic test_full();
    bit stopped = 1'b0;
    do_reset();
    ready_mode = 1'b0;
    ack_delay  = 0;
    for (int i = 0; i < 20 && !stopped; i++) begin
      step(1'b0, '0);
      if (bus.mem_req === 1'b0) stopped = 1'b1;
    end
    n_cmp++;
    if (!stopped || sb.size() != DEPTH || bus.mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL full_stop: stopped=%b entries=%0d addr=%h, required 1/%0d/00000010", stopped, sb.size(), bus.mem_addr, DEPTH);
    end
    repeat (3) step(1'b0, '0);
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL full_hold: req=%b addr=%h, required 0/00000010", bus.mem_req, bus.mem_addr);
    end
    ready_mode = 1'b1;
    step(1'b0, '0);
    ready_mode = 1'b0;
    step(1'b0, '0);
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL full_resume: req=%b addr=%h, required 1/00000010", bus.mem_req, bus.mem_addr);
    end
    ready_mode = 1'b1;
    repeat (8) step(1'b0, '0);
  endtask

  task automatic test_slow_ack();
    int p0;
    do_reset();
    ready_mode = 1'b1;
    ack_delay  = 3;
    p0 = pops;
    for (int i = 0; i < 100 && pops - p0 < 5; i++) step(1'b0, '0);
    n_cmp++;
    if (pops - p0 < 5) begin
      n_fail++;
      $display("FAIL slow_ack: got %0d pops in budget, required 5", pops - p0);
    end
  endtask

  task automatic test_redirect_drop();
    bit found = 1'b0;
    int p0;
    do_reset();
    ready_mode = 1'b0;
    ack_delay  = 2;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, '0);
      if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h8 && wait_cnt == 1) found = 1'b1;
    end
    n_cmp++;
    if (!found || bus.inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_setup: found=%b valid=%b, required 1/1", found, bus.inst_valid);
    end
    step(1'b1, 32'h0000_0100);
    step(1'b0, '0);
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL drop_flush: valid=%b req=%b addr=%h, required 0/1/00000008", bus.inst_valid, bus.mem_req, bus.mem_addr);
    end
    step(1'b0, '0);
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL drop_restart: req=%b addr=%h, required 1/00000100", bus.mem_req, bus.mem_addr);
    end
    ready_mode = 1'b1;
    p0 = pops;
    for (int i = 0; i < 40 && pops - p0 < 3; i++) step(1'b0, '0);
    n_cmp++;
    if (pops - p0 < 3) begin
      n_fail++;
      $display("FAIL drop_resume: got %0d pops, required 3", pops - p0);
    end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    ready_mode = 1'b1;
    ack_delay  = 0;
    repeat (4) step(1'b0, '0);
    step(1'b1, 32'h0000_0103);
    step(1'b0, '0);
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_ack: valid=%b req=%b addr=%h, required 0/1/00000100", bus.inst_valid, bus.mem_req, bus.mem_addr);
    end
    repeat (5) step(1'b0, '0);
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    do_reset();
    ready_mode = 1'b0;
    ack_delay  = 5;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, '0);
      if (sb.size() == 3 && bus.mem_req === 1'b1 && wait_cnt == 2) found = 1'b1;
    end
    n_cmp++;
    if (!found || bus.inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup: found=%b valid=%b, required 1/1", found, bus.inst_valid);
    end
    #2;
    rst         = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== RESET_PC || bus.inst_valid !== 1'b0 ||
        bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: req=%b addr=%h valid=%b inst=%h pc=%h, required all reset values",
               bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc);
    end
    clear_model();
    repeat (2) @(negedge clk);
    rst        = 1'b1;
    ready_mode = 1'b1;
    ack_delay  = 0;
    step(1'b0, '0);
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL midrst_restart: req=%b addr=%h, required 1/%h", bus.mem_req, bus.mem_addr, RESET_PC);
    end
    repeat (6) step(1'b0, '0);
  endtask

  task automatic test_wrap();
    do_reset();
    ready_mode = 1'b1;
    ack_delay  = 0;
    repeat (3) step(1'b0, '0);
    step(1'b1, 32'hFFFF_FFF8);
    step(1'b0, '0);
    n_cmp++;
    if (bus.mem_addr !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL wrap_start: addr=%h, required fffffff8", bus.mem_addr);
    end
    step(1'b0, '0);
    n_cmp++;
    if (bus.mem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_last: addr=%h, required fffffffc", bus.mem_addr);
    end
    step(1'b0, '0);
    n_cmp++;
    if (bus.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: addr=%h, required 00000000", bus.mem_addr);
    end
    repeat (4) step(1'b0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.inst_ready  = 1'b1;
    test_reset();
    test_stream();
    test_full();
    test_slow_ack();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
